// File: rtl/cvm_in_stager.sv
// Input stager for the 2-LUT DA complex vector multiplier: holds each x vector for FRAME cycles, double-buffered.
// Latency: accept to presentation 1 cycle; frames chain back-to-back with no bubble.
// Backpressure: in_ready drops while the skid slot is full, reopening in the last cycle of a frame. Option: CVM_UNDERRUN_CNT_EN.
module cvm_in_stager #(
   parameter int XW    = 8,
   parameter int FRAME = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4*XW-1:0] in_xr,
   input  logic [4*XW-1:0] in_xi,
   output logic [XW-1:0]   xr1,
   output logic [XW-1:0]   xr2,
   output logic [XW-1:0]   xr3,
   output logic [XW-1:0]   xr4,
   output logic [XW-1:0]   xi1,
   output logic [XW-1:0]   xi2,
   output logic [XW-1:0]   xi3,
   output logic [XW-1:0]   xi4,
`ifdef CVM_UNDERRUN_CNT_EN
   output logic [15:0]     underrun_cnt,
`endif
   output logic            frame_start,
   output logic            busy
);

   localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FRAME - 1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   typedef struct packed {
      logic [4*XW-1:0] xr;
      logic [4*XW-1:0] xi;
   } xvec_t;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   xvec_t         hold;
   xvec_t         pend;
   logic          pend_v;
   logic          frame_end;
   logic          accept;
   xvec_t         in_vec;

   assign in_vec.xr = in_xr;
   assign in_vec.xi = in_xi;

   assign frame_end = (state == RUN) && (cnt == CNT_LAST);
   // Ready depends only on registered state, never on in_valid.
   assign in_ready  = rst_n & (~pend_v | frame_end);
   assign accept    = in_valid & in_ready;
   assign busy      = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         hold        <= '0;
         pend        <= '0;
         pend_v      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  hold        <= in_vec;
                  cnt         <= '0;
                  state       <= RUN;
                  frame_start <= 1'b1;
               end
            end
            default: begin
               if (frame_end) begin
                  cnt <= '0;
                  if (pend_v) begin
                     hold        <= pend;
                     frame_start <= 1'b1;
                     if (accept) begin
                        pend <= in_vec;
                     end else begin
                        pend_v <= 1'b0;
                     end
                  end else if (accept) begin
                     hold        <= in_vec;
                     frame_start <= 1'b1;
                  end else begin
                     // Underrun: zero the outputs so the multiplier sees 0.
                     hold  <= '0;
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
                  if (accept) begin
                     pend   <= in_vec;
                     pend_v <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

`ifdef CVM_UNDERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underrun_cnt <= '0;
      end else if (frame_end && !pend_v && !accept && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'd1;
      end
   end
`endif

   assign xr1 = hold.xr[4*XW-1 -: XW];
   assign xr2 = hold.xr[3*XW-1 -: XW];
   assign xr3 = hold.xr[2*XW-1 -: XW];
   assign xr4 = hold.xr[XW-1   -: XW];
   assign xi1 = hold.xi[4*XW-1 -: XW];
   assign xi2 = hold.xi[3*XW-1 -: XW];
   assign xi3 = hold.xi[2*XW-1 -: XW];
   assign xi4 = hold.xi[XW-1   -: XW];

endmodule
